// File: rtl/plic_pkg.sv
// Shared types and sizing helpers for the PLIC per-target control stage.
package plic_pkg;

    localparam int DEF_SOURCES    = 16;
    localparam int DEF_PRIORITIES = 7;

    // Width needed to encode 0..n inclusive (ID 0 / priority 0 are reserved values).
    function automatic int bits_for(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEF_SOURCES_BITS  = bits_for(DEF_SOURCES);
    localparam int DEF_PRIORITY_BITS = bits_for(DEF_PRIORITIES);

    localparam int NO_IRQ_ID = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        CLAIMED = 1'b1
    } claim_state_e;

endpackage

// File: rtl/plic_claim_fsm.sv
// Claim/complete handshake for one outstanding claim per target.
//   state   | meaning
//   IDLE    | no claim outstanding; irq may be raised, claims are honoured
//   CLAIMED | claimed_q is in service; further claims read 0, complete must match
module plic_claim_fsm
    import plic_pkg::*;
#(
    parameter int SOURCES_BITS = DEF_SOURCES_BITS
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    eligible_i,
    input  logic [SOURCES_BITS-1:0] idx_q_i,
    input  logic                    claim_i,
    input  logic                    complete_i,
    input  logic [SOURCES_BITS-1:0] complete_id_i,
    output logic                    idle_o,
    output logic                    blank_o,
    output logic [SOURCES_BITS-1:0] id_o,
    output logic                    id_valid_o,
    output logic                    claim_req_o,
    output logic [SOURCES_BITS-1:0] claim_src_o,
    output logic                    complete_req_o,
    output logic [SOURCES_BITS-1:0] complete_src_o,
    output logic                    complete_err_o
);

    localparam logic [SOURCES_BITS-1:0] NO_ID = SOURCES_BITS'(NO_IRQ_ID);

    claim_state_e            state_q, state_d;
    logic [SOURCES_BITS-1:0] claimed_q, claimed_d;
    logic                    blank_q, blank_d;
    logic [SOURCES_BITS-1:0] id_q, id_d, claim_src_q, claim_src_d, complete_src_q, complete_src_d;
    logic                    id_valid_q, id_valid_d, claim_req_q, claim_req_d;
    logic                    complete_req_q, complete_req_d, complete_err_q, complete_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            claimed_q      <= '0;
            blank_q        <= 1'b0;
            id_q           <= '0;
            id_valid_q     <= 1'b0;
            claim_req_q    <= 1'b0;
            claim_src_q    <= '0;
            complete_req_q <= 1'b0;
            complete_src_q <= '0;
            complete_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            claimed_q      <= claimed_d;
            blank_q        <= blank_d;
            id_q           <= id_d;
            id_valid_q     <= id_valid_d;
            claim_req_q    <= claim_req_d;
            claim_src_q    <= claim_src_d;
            complete_req_q <= complete_req_d;
            complete_src_q <= complete_src_d;
            complete_err_q <= complete_err_d;
        end
    end

    // Both strobes are judged against the current state, so a simultaneous
    // claim+complete in CLAIMED reads 0 while the complete retires the claim.
    always_comb begin
        state_d        = state_q;
        claimed_d      = claimed_q;
        blank_d        = 1'b0;
        id_d           = id_q;
        id_valid_d     = 1'b0;
        claim_req_d    = 1'b0;
        claim_src_d    = claim_src_q;
        complete_req_d = 1'b0;
        complete_src_d = complete_src_q;
        complete_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (claim_i) begin
                    id_valid_d = 1'b1;
                    if (eligible_i) begin
                        id_d        = idx_q_i;
                        claim_req_d = 1'b1;
                        claim_src_d = idx_q_i;
                        claimed_d   = idx_q_i;
                        state_d     = CLAIMED;
                    end else begin
                        id_d = NO_ID;
                    end
                end
                if (complete_i) begin
                    complete_err_d = 1'b1;
                end
            end
            CLAIMED: begin
                if (claim_i) begin
                    id_valid_d = 1'b1;
                    id_d       = NO_ID;
                end
                if (complete_i) begin
                    if (complete_id_i == claimed_q) begin
                        complete_req_d = 1'b1;
                        complete_src_d = claimed_q;
                        state_d        = IDLE;
                        blank_d        = 1'b1;
                    end else begin
                        complete_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle_o         = (state_q == IDLE);
    assign blank_o        = blank_q;
    assign id_o           = id_q;
    assign id_valid_o     = id_valid_q;
    assign claim_req_o    = claim_req_q;
    assign claim_src_o    = claim_src_q;
    assign complete_req_o = complete_req_q;
    assign complete_src_o = complete_src_q;
    assign complete_err_o = complete_err_q;

endmodule

// File: rtl/plic_target_ctrl.sv
// PLIC per-target stage: registers the winning priority/ID, applies the threshold
// and drives irq_o; the claim/complete handshake lives in plic_claim_fsm.
module plic_target_ctrl
    import plic_pkg::*;
#(
    parameter int SOURCES       = DEF_SOURCES,
    parameter int PRIORITIES    = DEF_PRIORITIES,
    parameter int SOURCES_BITS  = bits_for(SOURCES),
    parameter int PRIORITY_BITS = bits_for(PRIORITIES)
)(
    input  logic                     rst_n,
    input  logic                     clk,
    input  logic [PRIORITY_BITS-1:0] priority_i,
    input  logic [SOURCES_BITS-1:0]  idx_i,
    input  logic [PRIORITY_BITS-1:0] threshold_i,
    input  logic                     claim_i,
    input  logic                     complete_i,
    input  logic [SOURCES_BITS-1:0]  complete_id_i,
    output logic                     irq_o,
    output logic [SOURCES_BITS-1:0]  id_o,
    output logic                     id_valid_o,
    output logic                     claim_req_o,
    output logic [SOURCES_BITS-1:0]  claim_src_o,
    output logic                     complete_req_o,
    output logic [SOURCES_BITS-1:0]  complete_src_o,
    output logic                     complete_err_o
);

    logic [PRIORITY_BITS-1:0] p_q;
    logic [SOURCES_BITS-1:0]  i_q;
    logic                     irq_q;
    logic                     eligible;
    logic                     idle;
    logic                     blank;

    // Priority 0 can never exceed any threshold, so it never interrupts.
    assign eligible = (p_q > threshold_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            i_q   <= '0;
            irq_q <= 1'b0;
        end else begin
            p_q   <= priority_i;
            i_q   <= idx_i;
            irq_q <= eligible && idle && !blank && !claim_i;
        end
    end

    assign irq_o = irq_q;

    plic_claim_fsm #(
        .SOURCES_BITS (SOURCES_BITS)
    ) u_claim_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .eligible_i     (eligible),
        .idx_q_i        (i_q),
        .claim_i        (claim_i),
        .complete_i     (complete_i),
        .complete_id_i  (complete_id_i),
        .idle_o         (idle),
        .blank_o        (blank),
        .id_o           (id_o),
        .id_valid_o     (id_valid_o),
        .claim_req_o    (claim_req_o),
        .claim_src_o    (claim_src_o),
        .complete_req_o (complete_req_o),
        .complete_src_o (complete_src_o),
        .complete_err_o (complete_err_o)
    );

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Scoreboard bench for plic_target_ctrl: stimulus pushes expected strobes, a negedge monitor pops and checks them.
module tb_plic_target_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] priority_i;
    logic [4:0] idx_i;
    logic [2:0] threshold_i;
    logic       claim_i;
    logic       complete_i;
    logic [4:0] complete_id_i;
    logic       irq_o;
    logic [4:0] id_o;
    logic       id_valid_o;
    logic       claim_req_o;
    logic [4:0] claim_src_o;
    logic       complete_req_o;
    logic [4:0] complete_src_o;
    logic       complete_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    int q_id[$];
    int q_claim[$];
    int q_cmp[$];
    int q_err[$];

    plic_target_ctrl dut (
        .rst_n          (rst_n),
        .clk            (clk),
        .priority_i     (priority_i),
        .idx_i          (idx_i),
        .threshold_i    (threshold_i),
        .claim_i        (claim_i),
        .complete_i     (complete_i),
        .complete_id_i  (complete_id_i),
        .irq_o          (irq_o),
        .id_o           (id_o),
        .id_valid_o     (id_valid_o),
        .claim_req_o    (claim_req_o),
        .claim_src_o    (claim_src_o),
        .complete_req_o (complete_req_o),
        .complete_src_o (complete_src_o),
        .complete_err_o (complete_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got unexpected pulse value %0d, expected no pulse (t=%0t)", name, act, $time);
    endtask

    always @(negedge clk) begin
        int e;
        if (id_valid_o) begin
            if (q_id.size() == 0) unexpected("id_valid", int'(id_o));
            else begin e = q_id.pop_front(); check("id_o", int'(id_o), e); end
        end
        if (claim_req_o) begin
            if (q_claim.size() == 0) unexpected("claim_req", int'(claim_src_o));
            else begin e = q_claim.pop_front(); check("claim_src_o", int'(claim_src_o), e); end
        end
        if (complete_req_o) begin
            if (q_cmp.size() == 0) unexpected("complete_req", int'(complete_src_o));
            else begin e = q_cmp.pop_front(); check("complete_src_o", int'(complete_src_o), e); end
        end
        if (complete_err_o) begin
            if (q_err.size() == 0) unexpected("complete_err", 1);
            else begin e = q_err.pop_front(); check("complete_err_o", 1, e); end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_claim();
        claim_i = 1'b1;
        step();
        claim_i = 1'b0;
    endtask

    task automatic do_complete(input logic [4:0] id);
        complete_i    = 1'b1;
        complete_id_i = id;
        step();
        complete_i    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irq_o"},          int'(irq_o), 0);
        check({tag, "_id_o"},           int'(id_o), 0);
        check({tag, "_id_valid_o"},     int'(id_valid_o), 0);
        check({tag, "_claim_req_o"},    int'(claim_req_o), 0);
        check({tag, "_claim_src_o"},    int'(claim_src_o), 0);
        check({tag, "_complete_req_o"}, int'(complete_req_o), 0);
        check({tag, "_complete_src_o"}, int'(complete_src_o), 0);
        check({tag, "_complete_err_o"}, int'(complete_err_o), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        priority_i    = 3'd0;
        idx_i         = 5'd0;
        threshold_i   = 3'd0;
        claim_i       = 1'b0;
        complete_i    = 1'b0;
        complete_id_i = 5'd0;

        // Reset values, with a priority already presented upstream
        priority_i = 3'd6;
        idx_i      = 5'd9;
        step(2);
        check_all_zero("reset");
        priority_i = 3'd0;
        idx_i      = 5'd0;
        #2 rst_n = 1'b1;
        step();

        // 2-cycle latency priority -> irq
        threshold_i = 3'd2;
        priority_i  = 3'd5;
        idx_i       = 5'd3;
        step();
        check("irq_latency_c1", int'(irq_o), 0);
        step();
        check("irq_latency_c2", int'(irq_o), 1);

        // Claim, then a second claim reads 0
        q_id.push_back(3);
        q_claim.push_back(3);
        do_claim();
        check("irq_after_claim", int'(irq_o), 0);
        q_id.push_back(0);
        do_claim();
        check("irq_claimed", int'(irq_o), 0);

        // Mismatched complete errors, state stays CLAIMED (next claim still reads 0)
        q_err.push_back(1);
        do_complete(5'd4);
        q_id.push_back(0);
        do_claim();
        check("irq_still_claimed", int'(irq_o), 0);

        // Matching complete, one blank cycle, then irq returns
        q_cmp.push_back(3);
        do_complete(5'd3);
        check("irq_complete_n1", int'(irq_o), 0);
        step();
        check("irq_blank", int'(irq_o), 0);
        step();
        check("irq_rearmed", int'(irq_o), 1);

        // Threshold equal to priority masks
        priority_i  = 3'd4;
        idx_i       = 5'd7;
        threshold_i = 3'd4;
        step(2);
        check("irq_thr_equal", int'(irq_o), 0);
        q_id.push_back(0);
        do_claim();
        threshold_i = 3'd3;
        step();
        check("irq_thr_lowered", int'(irq_o), 1);

        // Priority 0 never interrupts, even at threshold 0
        priority_i  = 3'd0;
        idx_i       = 5'd0;
        threshold_i = 3'd0;
        step(2);
        check("irq_prio0", int'(irq_o), 0);

        // Max priority against max threshold is masked
        priority_i  = 3'd7;
        idx_i       = 5'd16;
        threshold_i = 3'd7;
        step(2);
        check("irq_thr_max", int'(irq_o), 0);

        // Simultaneous claim+complete in CLAIMED
        priority_i  = 3'd5;
        idx_i       = 5'd3;
        threshold_i = 3'd2;
        step(2);
        check("irq_before_sim", int'(irq_o), 1);
        q_id.push_back(3);
        q_claim.push_back(3);
        do_claim();
        q_id.push_back(0);
        q_cmp.push_back(3);
        claim_i = 1'b1;
        do_complete(5'd3);
        claim_i = 1'b0;
        step(2);
        check("irq_after_sim_complete", int'(irq_o), 1);

        // Simultaneous claim+complete in IDLE: complete errors, claim succeeds
        q_err.push_back(1);
        q_id.push_back(3);
        q_claim.push_back(3);
        claim_i = 1'b1;
        do_complete(5'd5);
        claim_i = 1'b0;
        step();
        check("irq_sim_idle_claimed", int'(irq_o), 0);

        // Reset while CLAIMED drops the claim
        #2 rst_n = 1'b0;
        #1 check("irq_in_reset", int'(irq_o), 0);
        step(2);
        #2 rst_n = 1'b1;
        step();
        q_err.push_back(1);
        do_complete(5'd3);
        step(3);

        check("q_id_drained",    q_id.size(), 0);
        check("q_claim_drained", q_claim.size(), 0);
        check("q_cmp_drained",   q_cmp.size(), 0);
        check("q_err_drained",   q_err.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
